rob_retire: RTL and testbench
=============================

ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 DEPTH, 16, number of reorder-buffer entries; power of two.
REQ-002 PREG_W, 6, physical register index width (64 physical registers).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 alloc_valid  input  1  dispatch requests one ROB entry this cycle.
REQ-006 alloc_ready  output  1  an entry is free; high exactly when count < DEPTH.
REQ-007 alloc_has_dest  input  1  instruction writes a register; 0 for rd = x0 or no destination.
REQ-008 alloc_old_pd  input  PREG_W  previous RAT mapping of rd, to be freed at retire.
REQ-009 alloc_pc  input  32  instruction PC.
REQ-010 alloc_idx  output  log2(DEPTH)  tail index granted to the current request (combinational, equals tail).
REQ-011 cmpl_valid  input  1  a functional unit finished the instruction at cmpl_idx.
REQ-012 cmpl_idx  input  log2(DEPTH)  ROB index being marked complete.
REQ-013 free_valid  output  2  bit k high = free_preg_k is returned to the free pool this cycle.
REQ-014 free_preg0, free_preg1  output  PREG_W each  physical registers released, oldest in slot 0.
REQ-015 retire_pc0, retire_pc1  output  32 each  PCs of instructions retired, for trace.
REQ-016 retire_cnt  output  2  number of instructions retired this cycle (0..2).
REQ-017 count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-018 Per entry state: v, done, has_dest, old_pd, pc; head and tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-019 Allocation fires on the edge where alloc_valid && alloc_ready; entry[tail] is written with v=1, done=0, and tail increments.
REQ-020 alloc_ready uses the pre-edge count only; when full, a same-cycle retire does not enable allocation (no bypass).
REQ-021 On the edge with cmpl_valid, entry[cmpl_idx].done is set to 1 if v=1; a completion to an entry with v=0 is ignored.
REQ-022 Retirement is in order: on an edge, slot 0 retires entry[head] if v && done (pre-edge values); slot 1 retires entry[head+1] only if slot 0 retires and entry[head+1] is v && done.
REQ-023 A retired entry gets v=0, done=0; head advances by retire_cnt, modulo DEPTH.
REQ-024 Completion and retirement of the same entry on one edge: retirement uses the pre-edge done bit, so the entry retires no earlier than the edge after completion.
REQ-025 free_valid, free_preg*, retire_pc*, and retire_cnt are registered; they reflect the retirements of the previous edge and are valid for exactly one cycle.
REQ-026 free_valid[k] = slot k retired && has_dest; a retired entry with has_dest=0 drives retire_cnt but no free.
REQ-027 count_next = count + alloc_fire - retire_cnt; simultaneous allocation and retirement at the wrap boundary keep the pointers consistent.
REQ-028 Minimum latency is alloc edge N, completion edge N+1, retire edge N+2, and free_valid high during the cycle after N+2.
REQ-029 With count=0, nothing retires; a completion while empty is ignored per REQ-021.

Reset
REQ-030 While reset=1 on an edge: head=tail=0, count=0, all v=0 and done=0, free_valid=0, retire_cnt=0, free_preg*=0, retire_pc*=0.
REQ-031 Reset takes priority over alloc, completion and retirement on the same edge; in-flight entries are discarded and nothing is freed.
REQ-032 alloc_ready=1 during the first cycle after reset deasserts.

Verification
REQ-033 Single op: alloc pc=0x0, old_pd=5, has_dest=1, then cmpl idx 0 -> one cycle later free_valid=01, free_preg0=5, retire_cnt=1, count returns to 0.
REQ-034 Out-of-order completion: alloc idx 0,1,2 (old_pd 7,8,9); complete 2, then 1, then 0 -> no free until idx 0 completes; then one cycle with free_valid=11 (7, 8), then the next with free_valid=01 (9).
REQ-035 Full: 16 allocs -> alloc_ready=0, count=16; 17th request not accepted; complete and retire idx 0 -> alloc_ready=1 only the cycle after the retire edge.
REQ-036 Wrap: after 20 alloc/retire pairs, tail and head wrap 15 -> 0; alloc_idx sequence is 0..15,0..3, and the free order matches the alloc order.
REQ-037 has_dest=0 entry at head, completed with the next entry -> retire_cnt=2, free_valid=10, free_preg1 = old_pd of the second entry.
REQ-038 Reset with 5 entries in flight, 2 of them done -> the next cycle has count=0, free_valid=0, alloc_idx=0; later completions to old indices are ignored.

Source files
------------

// File: rtl/rob_retire.sv
// Purpose : reorder buffer bookkeeping; in-order retirement of up to two entries
//           per cycle, returning each retired entry's previous physical register.
// Latency : alloc edge N, complete edge N+1, retire edge N+2, free/retire outputs
//           valid for the one cycle after the retire edge.
// Backpressure: alloc_ready drops when all DEPTH entries are occupied; it is based
//           on the registered count only, so a same-cycle retire never bypasses it.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   alloc_valid / alloc_ready     dispatch handshake; alloc_idx is the granted slot
//   alloc_has_dest, alloc_old_pd  destination flag and register freed at retire
//   alloc_pc                      PC carried for the retire trace
//   cmpl_valid, cmpl_idx          functional-unit completion of one entry
//   free_valid, free_preg0/1      registered free-pool return, oldest in slot 0
//   retire_pc0/1, retire_cnt      registered retire trace
//   count                         occupied entries (0..DEPTH)
module rob_retire #(
  parameter  int DEPTH  = 16,
  parameter  int PREG_W = 6,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dest,
  input  logic [PREG_W-1:0] alloc_old_pd,
  input  logic [31:0]       alloc_pc,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_idx,
  output logic [1:0]        free_valid,
  output logic [PREG_W-1:0] free_preg0,
  output logic [PREG_W-1:0] free_preg1,
  output logic [31:0]       retire_pc0,
  output logic [31:0]       retire_pc1,
  output logic [1:0]        retire_cnt,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Payload fields are only ever read for entries whose valid bit is set, so
  // they carry no reset.
  typedef struct packed {
    logic              has_dest;
    logic [PREG_W-1:0] old_pd;
    logic [31:0]       pc;
  } rob_payload_t;

  rob_payload_t     payload [DEPTH];
  logic [DEPTH-1:0] ent_v;
  logic [DEPTH-1:0] ent_done;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  logic [IDX_W-1:0] head_p1;
  logic             alloc_fire;
  logic             ret0;
  logic             ret1;
  logic [1:0]       ret_cnt_next;
  rob_payload_t     head_ent;
  rob_payload_t     head_p1_ent;

  assign alloc_ready = (count < DEPTH_C);
  assign alloc_idx   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign head_p1     = head + IDX_W'(1);
  assign head_ent    = payload[head];
  assign head_p1_ent = payload[head_p1];

  // Retirement looks only at pre-edge valid/done, so an entry completing on
  // this edge retires on the next one at the earliest. Slot 1 may retire only
  // behind slot 0, keeping retirement strictly in order.
  always_comb begin
    ret0         = 1'b0;
    ret1         = 1'b0;
    ret_cnt_next = 2'd0;
    if (ent_v[head] && ent_done[head]) begin
      ret0 = 1'b1;
      if (ent_v[head_p1] && ent_done[head_p1]) begin
        ret1 = 1'b1;
      end
    end
    if (ret1) begin
      ret_cnt_next = 2'd2;
    end else if (ret0) begin
      ret_cnt_next = 2'd1;
    end
  end

  // Entry status, pointers and registered retire outputs.
  // Assignment order matters: a completion to an entry that is retiring on the
  // same edge is overridden by the retire clear. The allocated slot can never
  // collide with a retiring one: tail == head only when empty (nothing retires)
  // or full (nothing allocates).
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_v      <= '0;
      ent_done   <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      free_valid <= 2'b00;
      free_preg0 <= '0;
      free_preg1 <= '0;
      retire_pc0 <= '0;
      retire_pc1 <= '0;
      retire_cnt <= 2'd0;
    end else begin
      // Completions to empty slots are dropped.
      if (cmpl_valid && ent_v[cmpl_idx]) begin
        ent_done[cmpl_idx] <= 1'b1;
      end

      if (ret0) begin
        ent_v[head]    <= 1'b0;
        ent_done[head] <= 1'b0;
      end
      if (ret1) begin
        ent_v[head_p1]    <= 1'b0;
        ent_done[head_p1] <= 1'b0;
      end

      if (alloc_fire) begin
        ent_v[tail]    <= 1'b1;
        ent_done[tail] <= 1'b0;
        tail           <= tail + IDX_W'(1);
      end

      // Pointers wrap naturally since DEPTH is a power of two.
      head  <= head + IDX_W'(ret_cnt_next);
      count <= count + CNT_W'(alloc_fire) - CNT_W'(ret_cnt_next);

      // A retired entry without a destination still counts as retired but
      // returns nothing to the free pool; unused slots are driven to zero.
      free_valid[0] <= ret0 && head_ent.has_dest;
      free_valid[1] <= ret1 && head_p1_ent.has_dest;
      free_preg0    <= (ret0 && head_ent.has_dest)    ? head_ent.old_pd    : '0;
      free_preg1    <= (ret1 && head_p1_ent.has_dest) ? head_p1_ent.old_pd : '0;
      retire_pc0    <= ret0 ? head_ent.pc    : 32'd0;
      retire_pc1    <= ret1 ? head_p1_ent.pc : 32'd0;
      retire_cnt    <= ret_cnt_next;
    end
  end

  // Payload capture at allocation.
  always_ff @(posedge clk) begin
    if (!reset && alloc_fire) begin
      payload[tail] <= '{has_dest: alloc_has_dest, old_pd: alloc_old_pd, pc: alloc_pc};
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Purpose : self-checking bench for rob_retire; a queue-based model of the
//           in-flight instructions is checked every cycle, and directed
//           scenarios add hand-computed literal expectations.
module tb_rob_retire;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_has_dest;
  logic [5:0]  alloc_old_pd;
  logic [31:0] alloc_pc;
  logic [3:0]  alloc_idx;
  logic        cmpl_valid;
  logic [3:0]  cmpl_idx;
  logic [1:0]  free_valid;
  logic [5:0]  free_preg0;
  logic [5:0]  free_preg1;
  logic [31:0] retire_pc0;
  logic [31:0] retire_pc1;
  logic [1:0]  retire_cnt;
  logic [4:0]  count;

  rob_retire #(.DEPTH(16), .PREG_W(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_dest (alloc_has_dest),
    .alloc_old_pd   (alloc_old_pd),
    .alloc_pc       (alloc_pc),
    .alloc_idx      (alloc_idx),
    .cmpl_valid     (cmpl_valid),
    .cmpl_idx       (cmpl_idx),
    .free_valid     (free_valid),
    .free_preg0     (free_preg0),
    .free_preg1     (free_preg1),
    .retire_pc0     (retire_pc0),
    .retire_pc1     (retire_pc1),
    .retire_cnt     (retire_cnt),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight instructions in program order; each remembers the slot it got.
  typedef struct {
    int idx;
    bit hd;
    int pd;
    int pc;
    bit done;
  } ent_t;

  ent_t   mq[$];
  ent_t   m_new;
  int     m_tail;
  int     m_n;
  bit     m_fire;
  bit     model_live = 1'b0;
  bit [1:0] m_fv;
  int     m_fp0, m_fp1, m_pc0, m_pc1, m_rc;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_tail = 0;
      m_fv = 2'b00; m_rc = 0;
      m_fp0 = 0; m_fp1 = 0; m_pc0 = 0; m_pc1 = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      // Oldest instructions leave if already finished before this edge.
      m_n = 0;
      if (mq.size() > 0 && mq[0].done) m_n = 1;
      if (m_n == 1 && mq.size() > 1 && mq[1].done) m_n = 2;
      m_rc = m_n;
      m_fv = 2'b00;
      if (m_n >= 1) begin m_fv[0] = mq[0].hd; m_fp0 = mq[0].pd; m_pc0 = mq[0].pc; end
      if (m_n == 2) begin m_fv[1] = mq[1].hd; m_fp1 = mq[1].pd; m_pc1 = mq[1].pc; end
      m_fire = alloc_valid && (mq.size() < 16);
      if (cmpl_valid) begin
        foreach (mq[i]) if (mq[i].idx == int'(cmpl_idx)) mq[i].done = 1'b1;
      end
      repeat (m_n) mq.delete(0);
      if (m_fire) begin
        m_new.idx  = m_tail;
        m_new.hd   = alloc_has_dest;
        m_new.pd   = int'(alloc_old_pd);
        m_new.pc   = int'(alloc_pc);
        m_new.done = 1'b0;
        mq.push_back(m_new);
        m_tail = (m_tail + 1) % 16;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_ready", 32'(alloc_ready), 32'(mq.size() < 16));
      chk("m_idx", 32'(alloc_idx), 32'(m_tail));
      chk("m_rcnt", 32'(retire_cnt), 32'(m_rc));
      chk("m_fv", 32'(free_valid), 32'(m_fv));
      if (m_fv[0]) chk("m_fp0", 32'(free_preg0), 32'(m_fp0));
      if (m_fv[1]) chk("m_fp1", 32'(free_preg1), 32'(m_fp1));
      if (m_rc >= 1) chk("m_pc0", retire_pc0, 32'(m_pc0));
      if (m_rc == 2) chk("m_pc1", retire_pc1, 32'(m_pc1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_old_pd = '0; alloc_pc = '0;
    cmpl_valid = 1'b0; cmpl_idx = '0;
  endtask

  task automatic set_alloc(input int pd, input bit hd, input int pc);
    alloc_valid = 1'b1; alloc_has_dest = hd; alloc_old_pd = 6'(pd); alloc_pc = 32'(pc);
  endtask

  task automatic do_alloc(input int pd, input bit hd, input int pc);
    set_alloc(pd, hd, pc);
    tick();
    idle_in();
  endtask

  task automatic do_cmpl(input int idx);
    cmpl_valid = 1'b1; cmpl_idx = 4'(idx);
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_idx", 32'(alloc_idx), 32'd0);
    chk("rst_fv", 32'(free_valid), 32'd0);
    chk("rst_rcnt", 32'(retire_cnt), 32'd0);

    // Single op, minimum latency.
    do_alloc(5, 1'b1, 32'h0);
    chk("single_count1", 32'(count), 32'd1);
    do_cmpl(0);
    chk("single_nofree_at_cmpl", 32'(free_valid), 32'd0);
    tick();
    chk("single_fv", 32'(free_valid), 32'd1);
    chk("single_fp0", 32'(free_preg0), 32'd5);
    chk("single_rcnt", 32'(retire_cnt), 32'd1);
    chk("single_count0", 32'(count), 32'd0);
    tick();
    chk("single_fv_pulse", 32'(free_valid), 32'd0);

    // Out-of-order completion.
    do_reset();
    do_alloc(7, 1'b1, 32'h100);
    do_alloc(8, 1'b1, 32'h104);
    do_alloc(9, 1'b1, 32'h108);
    do_cmpl(2);
    chk("ooo_nofree_a", 32'(free_valid), 32'd0);
    do_cmpl(1);
    chk("ooo_nofree_b", 32'(free_valid), 32'd0);
    do_cmpl(0);
    chk("ooo_nofree_c", 32'(free_valid), 32'd0);
    tick();
    chk("ooo_fv11", 32'(free_valid), 32'd3);
    chk("ooo_fp0", 32'(free_preg0), 32'd7);
    chk("ooo_fp1", 32'(free_preg1), 32'd8);
    chk("ooo_rcnt2", 32'(retire_cnt), 32'd2);
    tick();
    chk("ooo_fv01", 32'(free_valid), 32'd1);
    chk("ooo_fp0_last", 32'(free_preg0), 32'd9);
    chk("ooo_empty", 32'(count), 32'd0);

    // Full, no bypass of a same-cycle retire.
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(i + 1, 1'b1, 32'h2000 + 4 * i);
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    set_alloc(40, 1'b1, 32'hdead);
    tick();
    chk("full_reject_count", 32'(count), 32'd16);
    chk("full_reject_idx", 32'(alloc_idx), 32'd0);
    cmpl_valid = 1'b1; cmpl_idx = 4'd0;
    tick();
    cmpl_valid = 1'b0;
    chk("full_ready_at_cmpl", 32'(alloc_ready), 32'd0);
    tick();
    chk("full_ready_after_ret", 32'(alloc_ready), 32'd1);
    chk("full_count15", 32'(count), 32'd15);
    chk("full_fp0", 32'(free_preg0), 32'd1);
    tick();
    idle_in();
    chk("full_refill", 32'(count), 32'd16);
    for (int i = 1; i < 16; i++) do_cmpl(i);
    do_cmpl(0);
    repeat (10) tick();
    chk("full_drained", 32'(count), 32'd0);

    // Wrap with overlapping alloc, completion and retirement.
    do_reset();
    for (int t = 0; t < 22; t++) begin
      idle_in();
      if (t < 20) begin
        chk("wrap_idx", 32'(alloc_idx), 32'(t % 16));
        set_alloc((t + 10) % 64, 1'b1, 32'h1000 + 4 * t);
      end
      if (t >= 1 && t <= 20) begin
        cmpl_valid = 1'b1; cmpl_idx = 4'((t - 1) % 16);
      end
      tick();
      if (t >= 2) begin
        chk("wrap_fv", 32'(free_valid), 32'd1);
        chk("wrap_order", 32'(free_preg0), 32'((t - 2 + 10) % 64));
      end
    end
    idle_in();
    tick();
    chk("wrap_empty", 32'(count), 32'd0);

    // No-destination entry at head retiring with the next one.
    do_reset();
    do_alloc(11, 1'b0, 32'h200);
    do_alloc(12, 1'b1, 32'h204);
    do_cmpl(1);
    do_cmpl(0);
    tick();
    chk("nodest_rcnt", 32'(retire_cnt), 32'd2);
    chk("nodest_fv", 32'(free_valid), 32'd2);
    chk("nodest_fp1", 32'(free_preg1), 32'd12);
    chk("nodest_pc0", retire_pc0, 32'h200);
    chk("nodest_pc1", retire_pc1, 32'h204);

    // Reset with work in flight, racing an alloc and a completion.
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(20 + i, 1'b1, 32'h300 + 4 * i);
    do_cmpl(1);
    do_cmpl(2);
    reset = 1'b1;
    set_alloc(50, 1'b1, 32'h400);
    cmpl_valid = 1'b1; cmpl_idx = 4'd0;
    tick();
    reset = 1'b0;
    idle_in();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_fv", 32'(free_valid), 32'd0);
    chk("flush_idx", 32'(alloc_idx), 32'd0);
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    do_cmpl(3);
    do_cmpl(0);
    tick();
    chk("flush_stale_count", 32'(count), 32'd0);
    chk("flush_stale_rcnt", 32'(retire_cnt), 32'd0);
    do_alloc(30, 1'b1, 32'h500);
    tick();
    chk("flush_new_not_done", 32'(free_valid), 32'd0);
    do_cmpl(0);
    tick();
    chk("flush_new_fp0", 32'(free_preg0), 32'd30);
    chk("flush_new_fv", 32'(free_valid), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
